// File: rtl/irq_arbiter_pkg.sv
// Shared definitions for the interrupt arbiter: config register map and source count.
package irq_arbiter_pkg;

  localparam int IRQ_NUM_SRC = 7;

  typedef enum logic [1:0] {
    IRQ_CFG_ENABLE    = 2'd0,
    IRQ_CFG_EDGE      = 2'd1,
    IRQ_CFG_PENDING   = 2'd2,
    IRQ_CFG_INSERVICE = 2'd3
  } irq_cfg_addr_e;

endpackage

// File: rtl/irq_arbiter_sync.sv
// Per-bit multi-flop synchronizer (irq_sync) for asynchronous interrupt lines; clears on reset.
module irq_arbiter_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stage_q <= '0;
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/irq_arbiter.sv
// Interrupt controller for the execute stage: synchronizes seven sources, applies enable/edge
// config, presents the highest eligible code above the current in-service level, tracks EOI.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [6:0] RESET_ENABLE = 7'h00,
  parameter logic [6:0] RESET_EDGE   = 7'h00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  irq_i,
  input  logic        exc_i,
  output logic [2:0]  interrupts_o,
  input  logic        cfg_we_i,
  input  logic [1:0]  cfg_addr_i,
  input  logic [31:0] cfg_data_i,
  output logic [31:0] cfg_data_o
);

  // Vectors are indexed by source number so bit k lines up with register bit k.
  logic [7:1] sync_w;
  logic [7:1] level_q;
  logic [7:1] latch_q, latch_d;
  logic [7:1] enable_q, enable_d;
  logic [7:1] edge_q, edge_d;
  logic [7:1] inservice_q, inservice_d;
  logic [7:1] wdata, w1c, exc_mask, rise, pending, eligible;
  logic [7:0] last_onehot;
  logic [2:0] code_q, code_d, last_code_q, is_top;
  logic       eoi, exc_take;
  logic       unused_cfg_bits;

  function automatic logic [2:0] top_index(input logic [7:1] v);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 1; k <= 7; k++) begin
      if (v[k]) r = 3'(k);
    end
    return r;
  endfunction

  function automatic logic [7:1] clear_top(input logic [7:1] v);
    logic [7:1] r;
    logic       done;
    r    = v;
    done = 1'b0;
    for (int k = 7; k >= 1; k--) begin
      if (v[k] && !done) begin
        r[k] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [7:1] above(input logic [2:0] idx);
    logic [7:1] r;
    for (int k = 1; k <= 7; k++) begin
      r[k] = (3'(k) > idx);
    end
    return r;
  endfunction

  irq_arbiter_sync #(
    .STAGES(SYNC_STAGES),
    .WIDTH (IRQ_NUM_SRC)
  ) u_irq_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (irq_i),
    .q_o  (sync_w)
  );

  assign unused_cfg_bits = ^{cfg_data_i[31:8], cfg_data_i[0]};

  always_comb begin
    wdata    = cfg_data_i[7:1];
    enable_d = enable_q;
    edge_d   = edge_q;
    w1c      = '0;
    eoi      = 1'b0;
    if (cfg_we_i) begin
      case (cfg_addr_i)
        IRQ_CFG_ENABLE:    enable_d = wdata;
        IRQ_CFG_EDGE:      edge_d   = wdata;
        IRQ_CFG_PENDING:   w1c      = wdata;
        IRQ_CFG_INSERVICE: eoi      = 1'b1;
        default:           ;
      endcase
    end

    // last_code is what the execute stage saw when it raised exc_i.
    exc_take    = exc_i && (last_code_q != 3'd0);
    last_onehot = 8'b1 << last_code_q;
    exc_mask    = exc_take ? last_onehot[7:1] : '0;

    // A new rising edge beats a same-cycle clear; leaving edge mode drops the latch.
    rise    = sync_w & ~level_q;
    latch_d = ((latch_q & ~w1c & ~exc_mask) | rise) & edge_d;

    inservice_d = (eoi ? clear_top(inservice_q) : inservice_q) | exc_mask;

    pending  = (edge_q & latch_q) | (~edge_q & level_q);
    eligible = pending & enable_q;
    is_top   = top_index(inservice_q);
    code_d   = top_index(eligible & above(is_top));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q     <= '0;
      latch_q     <= '0;
      enable_q    <= RESET_ENABLE;
      edge_q      <= RESET_EDGE;
      inservice_q <= '0;
      code_q      <= 3'd0;
      last_code_q <= 3'd0;
    end else begin
      level_q     <= sync_w;
      latch_q     <= latch_d;
      enable_q    <= enable_d;
      edge_q      <= edge_d;
      inservice_q <= inservice_d;
      code_q      <= code_d;
      last_code_q <= code_q;
    end
  end

  assign interrupts_o = code_q;

  always_comb begin
    cfg_data_o = '0;
    case (cfg_addr_i)
      IRQ_CFG_ENABLE:    cfg_data_o[7:1] = enable_q;
      IRQ_CFG_EDGE:      cfg_data_o[7:1] = edge_q;
      IRQ_CFG_PENDING:   cfg_data_o[7:1] = pending;
      IRQ_CFG_INSERVICE: cfg_data_o[7:1] = inservice_q;
      default:           cfg_data_o = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus random traffic against a reference model.
module tb_irq_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [6:0]  irq_i;
  logic        exc_i;
  logic [2:0]  interrupts_o;
  logic        cfg_we_i;
  logic [1:0]  cfg_addr_i;
  logic [31:0] cfg_data_i;
  logic [31:0] cfg_data_o;

  int total = 0;
  int bad   = 0;

  irq_arbiter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .irq_i       (irq_i),
    .exc_i       (exc_i),
    .interrupts_o(interrupts_o),
    .cfg_we_i    (cfg_we_i),
    .cfg_addr_i  (cfg_addr_i),
    .cfg_data_i  (cfg_data_i),
    .cfg_data_o  (cfg_data_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: per-source flags, a sample history for the sync delay, and the presented code.
  bit        m_en    [1:7];
  bit        m_edge  [1:7];
  bit        m_latch [1:7];
  bit        m_is    [1:7];
  bit [6:0]  m_hist  [$];
  int        m_code;
  int        m_last;

  function automatic bit m_pending(int k);
    if (m_edge[k]) return m_latch[k];
    return m_hist[2][k-1];
  endfunction

  function automatic int m_select();
    int top = 0;
    for (int k = 1; k <= 7; k++) if (m_is[k]) top = k;
    for (int k = 7; k > top; k--) if (m_en[k] && m_pending(k)) return k;
    return 0;
  endfunction

  function automatic int m_read(int addr);
    int v = 0;
    for (int k = 1; k <= 7; k++) begin
      case (addr)
        0: if (m_en[k])       v += (1 << k);
        1: if (m_edge[k])     v += (1 << k);
        2: if (m_pending(k))  v += (1 << k);
        default: if (m_is[k]) v += (1 << k);
      endcase
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 1; k <= 7; k++) begin
      m_en[k] = 1'b0; m_edge[k] = 1'b0; m_latch[k] = 1'b0; m_is[k] = 1'b0;
    end
    m_hist.delete();
    repeat (4) m_hist.push_back(7'h00);
    m_code = 0;
    m_last = 0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: advance the model from the inputs now on the pins, then compare the code.
  task automatic step();
    int       nxt, take;
    bit [6:0] rise;
    nxt  = m_select();
    take = (exc_i && m_last != 0) ? m_last : 0;
    m_hist.push_front(irq_i);
    void'(m_hist.pop_back());
    rise = m_hist[2] & ~m_hist[3];
    if (cfg_we_i && cfg_addr_i == 2'd0) for (int k = 1; k <= 7; k++) m_en[k] = cfg_data_i[k];
    if (cfg_we_i && cfg_addr_i == 2'd1) for (int k = 1; k <= 7; k++) m_edge[k] = cfg_data_i[k];
    if (cfg_we_i && cfg_addr_i == 2'd3) begin
      for (int k = 7; k >= 1; k--) if (m_is[k]) begin m_is[k] = 1'b0; break; end
    end
    if (take != 0) m_is[take] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      if (!m_edge[k]) m_latch[k] = 1'b0;
      else if (rise[k-1]) m_latch[k] = 1'b1;
      else if ((cfg_we_i && cfg_addr_i == 2'd2 && cfg_data_i[k]) || take == k) m_latch[k] = 1'b0;
    end
    m_last = m_code;
    m_code = nxt;
    @(posedge clk_i);
    #1;
    check("code", {29'd0, interrupts_o}, m_code);
  endtask

  task automatic steps(int n);
    repeat (n) step();
  endtask

  task automatic cfg_write(logic [1:0] addr, logic [31:0] data);
    cfg_we_i = 1'b1; cfg_addr_i = addr; cfg_data_i = data;
    step();
    cfg_we_i = 1'b0; cfg_data_i = '0;
  endtask

  task automatic exc_pulse();
    exc_i = 1'b1;
    step();
    exc_i = 1'b0;
  endtask

  task automatic read_chk(string tag, logic [1:0] addr);
    cfg_addr_i = addr;
    #1;
    check(tag, cfg_data_o, m_read(addr));
  endtask

  task automatic read_const(string tag, logic [1:0] addr, logic [31:0] exp);
    cfg_addr_i = addr;
    #1;
    check(tag, cfg_data_o, exp);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    irq_i = '0; exc_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_data_i = '0;
    #1;
    m_reset();
    check("rst_code", {29'd0, interrupts_o}, 32'd0);
    read_const("rst_enable", 2'd0, 32'h0);
    read_const("rst_edge", 2'd1, 32'h0);
    read_const("rst_pending", 2'd2, 32'h0);
    read_const("rst_inservice", 2'd3, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    do_reset();

    // Level source 5: code appears exactly three cycles after the sampling edge and holds.
    cfg_write(2'd0, 32'h7E);
    irq_i = 7'h10;
    step(); check("lvl_lat1", {29'd0, interrupts_o}, 32'd0);
    step(); check("lvl_lat2", {29'd0, interrupts_o}, 32'd0);
    step(); check("lvl_lat3", {29'd0, interrupts_o}, 32'd0);
    step(); check("lvl_code5", {29'd0, interrupts_o}, 32'd5);
    steps(3); check("lvl_hold5", {29'd0, interrupts_o}, 32'd5);

    // Edge sources 3 and 6 pulsed together: 6 first, 3 only after EOI.
    irq_i = 7'h00;
    cfg_write(2'd1, 32'h48);
    cfg_write(2'd0, 32'hFE);
    steps(4);
    irq_i = 7'h24;
    step();
    irq_i = 7'h00;
    steps(3);
    check("edge_code6", {29'd0, interrupts_o}, 32'd6);
    step();
    exc_pulse();
    read_const("edge_is40", 2'd3, 32'h40);
    read_chk("edge_pend", 2'd2);
    steps(3);
    check("edge_blocked", {29'd0, interrupts_o}, 32'd0);
    cfg_write(2'd3, 32'h0);
    step();
    check("edge_code3", {29'd0, interrupts_o}, 32'd3);

    // Nesting: source 3 in service, source 6 preempts.
    step();
    exc_pulse();
    read_const("nest_is08", 2'd3, 32'h08);
    irq_i = 7'h20;
    step();
    irq_i = 7'h00;
    steps(3);
    check("nest_code6", {29'd0, interrupts_o}, 32'd6);
    step();
    exc_pulse();
    read_const("nest_is48", 2'd3, 32'h48);
    cfg_write(2'd3, 32'h0);
    read_const("nest_eoi1", 2'd3, 32'h08);
    cfg_write(2'd3, 32'h0);
    read_const("nest_eoi2", 2'd3, 32'h00);

    // W1C racing a new edge on source 2: the set wins.
    cfg_write(2'd1, 32'h04);
    irq_i = 7'h02; step();
    irq_i = 7'h00; steps(2);
    read_const("w1c_first", 2'd2, 32'h04);
    irq_i = 7'h02; step();
    irq_i = 7'h00; step();
    cfg_write(2'd2, 32'h04);
    read_const("w1c_race", 2'd2, 32'h04);
    cfg_write(2'd2, 32'h04);
    read_const("w1c_clear", 2'd2, 32'h00);

    // All sources asserted but disabled: nothing presented, stray exc ignored.
    cfg_write(2'd1, 32'h0);
    cfg_write(2'd0, 32'h0);
    irq_i = 7'h7F;
    for (int i = 0; i < 5; i++) begin
      step();
      check("dis_code0", {29'd0, interrupts_o}, 32'd0);
    end
    exc_pulse();
    read_const("dis_is0", 2'd3, 32'h0);
    read_chk("dis_pend", 2'd2);

    // Random traffic against the model.
    irq_i = 7'h00;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3) == 0) irq_i = 7'($urandom);
      exc_i = ($urandom_range(5) == 0);
      if ($urandom_range(7) == 0) begin
        cfg_we_i   = 1'b1;
        cfg_addr_i = 2'($urandom);
        cfg_data_i = $urandom;
      end
      step();
      cfg_we_i = 1'b0; cfg_data_i = '0; exc_i = 1'b0;
      read_chk("rnd_read", 2'($urandom));
    end

    // Reset while code 7 is presented and in service.
    do_reset();
    cfg_write(2'd0, 32'hFE);
    irq_i = 7'h40;
    steps(4);
    check("rst7_code", {29'd0, interrupts_o}, 32'd7);
    step();
    exc_pulse();
    check("rst7_still", {29'd0, interrupts_o}, 32'd7);
    read_const("rst7_is80", 2'd3, 32'h80);
    do_reset();
    steps(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
